// File: rtl/debug_uart_dumper_if.sv
// ----------------------------------------------------------------------------
// debug_uart_dumper_if
//   Groups the debug-dump signals between the core side and the UART dumper.
//   master : drives trigger and the four debug words, observes tx/busy/dropped
//   slave  : the dumper; samples trigger/words, drives tx/busy/dropped
// Signals
//   trigger  1   0->1 transition requests a dump (synchronous to clk)
//   word0    32  pc
//   word1    32  data memory address
//   word2    32  instruction
//   word3    32  selected register
//   tx       1   UART serial out, idle high
//   busy     1   high while a frame is in flight
//   dropped  8   saturating count of triggers ignored while busy
// ----------------------------------------------------------------------------
interface debug_uart_dumper_if;
   logic        trigger;
   logic [31:0] word0;
   logic [31:0] word1;
   logic [31:0] word2;
   logic [31:0] word3;
   logic        tx;
   logic        busy;
   logic [7:0]  dropped;

   modport master (
      output trigger, word0, word1, word2, word3,
      input  tx, busy, dropped
   );

   modport slave (
      input  trigger, word0, word1, word2, word3,
      output tx, busy, dropped
   );
endinterface

// File: rtl/debug_uart_dumper.sv
// ----------------------------------------------------------------------------
// debug_uart_dumper
//   On each rising edge of trigger, snapshots the four 32-bit debug words and
//   streams them over an 8N1 UART as uppercase ASCII hex:
//      "PPPPPPPP AAAAAAAA IIIIIIII RRRRRRRR\r\n"  (37 chars)
//   Optional feature macro: DEBUG_DUMP_SEQ_EN
//      defined   -> frame prefixed with "SS:" (8-bit sequence number in hex,
//                   advances once per completed frame), 40 chars per frame.
//      undefined -> 37-char frame, no sequence register.
// Parameters
//   CLKS_PER_BIT  clk cycles per UART bit (2..65535)
// Ports
//   clk   in  board clock, posedge
//   rst   in  asynchronous active-high reset
//   dbg   debug_uart_dumper_if.slave (trigger, word0..3 in; tx, busy, dropped out)
// ----------------------------------------------------------------------------
module debug_uart_dumper #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                clk,
   input  logic                rst,
   debug_uart_dumper_if.slave  dbg
);

`ifdef DEBUG_DUMP_SEQ_EN
   localparam int PREFIX_LEN = 3;
`else
   localparam int PREFIX_LEN = 0;
`endif
   localparam int          FRAME_LEN = 37 + PREFIX_LEN;
   localparam logic [5:0]  LAST_CHAR = 6'(FRAME_LEN - 1);
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t         state_reg;
   logic           trigger_q;
   logic [127:0]   snap_reg;
   logic [5:0]     char_idx_reg;
   logic [2:0]     bit_idx_reg;
   logic [15:0]    baud_reg;
   logic           tx_reg;
   logic           busy_reg;
   logic [7:0]     dropped_reg;
`ifdef DEBUG_DUMP_SEQ_EN
   logic [7:0]     seq_reg;
`endif

   logic           launch;
   logic           bit_done;
   logic [7:0]     char_byte;
   logic [5:0]     ci;
   logic [1:0]     grp;
   logic [5:0]     pos;
   logic [6:0]     nib_sel;

   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
   endfunction

   assign launch   = dbg.trigger & ~trigger_q;
   assign bit_done = (baud_reg == 16'd0);

   assign dbg.tx      = tx_reg;
   assign dbg.busy    = busy_reg;
   assign dbg.dropped = dropped_reg;

   // Character currently being sent, derived from char index and snapshot.
   // Each word occupies 9 slots (8 nibbles + separator); slots 35/36 are CR/LF.
   always_comb begin
      char_byte = 8'h20;
      ci        = char_idx_reg - 6'(PREFIX_LEN);
      if (ci < 6'd9) begin
         grp = 2'd0; pos = ci;
      end else if (ci < 6'd18) begin
         grp = 2'd1; pos = ci - 6'd9;
      end else if (ci < 6'd27) begin
         grp = 2'd2; pos = ci - 6'd18;
      end else begin
         grp = 2'd3; pos = ci - 6'd27;
      end
      // snapshot is {word0, word1, word2, word3}; pos 0 is the top nibble
      nib_sel = 7'd127 - {grp, 5'd0} - {2'd0, pos[2:0], 2'd0};
      if (ci == 6'd35)
         char_byte = 8'h0D;
      else if (ci == 6'd36)
         char_byte = 8'h0A;
      else if (pos == 6'd8)
         char_byte = 8'h20;
      else
         char_byte = hex_ascii(snap_reg[nib_sel -: 4]);
`ifdef DEBUG_DUMP_SEQ_EN
      if (char_idx_reg == 6'd0)
         char_byte = hex_ascii(seq_reg[7:4]);
      else if (char_idx_reg == 6'd1)
         char_byte = hex_ascii(seq_reg[3:0]);
      else if (char_idx_reg == 6'd2)
         char_byte = 8'h3A;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         trigger_q    <= 1'b0;
         snap_reg     <= '0;
         char_idx_reg <= '0;
         bit_idx_reg  <= '0;
         baud_reg     <= '0;
         tx_reg       <= 1'b1;
         busy_reg     <= 1'b0;
         dropped_reg  <= '0;
`ifdef DEBUG_DUMP_SEQ_EN
         seq_reg      <= '0;
`endif
      end else begin
         trigger_q <= dbg.trigger;

         if (launch && (state_reg != IDLE) && (dropped_reg != 8'hFF))
            dropped_reg <= dropped_reg + 8'd1;

         // Counter free-runs down inside a bit and reloads on each boundary.
         if (state_reg != IDLE && !bit_done)
            baud_reg <= baud_reg - 16'd1;

         case (state_reg)
            IDLE: begin
               tx_reg <= 1'b1;
               if (launch) begin
                  snap_reg     <= {dbg.word0, dbg.word1, dbg.word2, dbg.word3};
                  char_idx_reg <= '0;
                  baud_reg     <= BIT_LAST;
                  tx_reg       <= 1'b0;
                  busy_reg     <= 1'b1;
                  state_reg    <= START;
               end
            end
            START: begin
               if (bit_done) begin
                  baud_reg    <= BIT_LAST;
                  bit_idx_reg <= 3'd0;
                  tx_reg      <= char_byte[0];
                  state_reg   <= DATA;
               end
            end
            DATA: begin
               if (bit_done) begin
                  baud_reg <= BIT_LAST;
                  if (bit_idx_reg == 3'd7) begin
                     tx_reg    <= 1'b1;
                     state_reg <= STOP;
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 3'd1;
                     tx_reg      <= char_byte[bit_idx_reg + 3'd1];
                  end
               end
            end
            STOP: begin
               if (bit_done) begin
                  if (char_idx_reg == LAST_CHAR) begin
                     busy_reg  <= 1'b0;
                     state_reg <= IDLE;
`ifdef DEBUG_DUMP_SEQ_EN
                     seq_reg   <= seq_reg + 8'd1;
`endif
                  end else begin
                     // next char starts immediately, no idle gap
                     char_idx_reg <= char_idx_reg + 6'd1;
                     baud_reg     <= BIT_LAST;
                     tx_reg       <= 1'b0;
                     state_reg    <= START;
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_uart_dumper.sv
// ----------------------------------------------------------------------------
// tb_debug_uart_dumper
//   Scoreboard bench for debug_uart_dumper with CLKS_PER_BIT=4. Expected
//   characters are queued when a dump is requested; a UART monitor sampling
//   mid-bit pops and compares each received character.
// ----------------------------------------------------------------------------
module tb_debug_uart_dumper;
   localparam int CPB = 4;
`ifdef DEBUG_DUMP_SEQ_EN
   localparam int FRAME_LEN = 40;
`else
   localparam int FRAME_LEN = 37;
`endif
   localparam int FRAME_CYC = FRAME_LEN * 10 * CPB;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   debug_uart_dumper_if dbg ();

   debug_uart_dumper #(.CLKS_PER_BIT(CPB)) dut (
      .clk (clk),
      .rst (rst),
      .dbg (dbg.slave)
   );

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] exp_q[$];
   int         rx_count = 0;
   logic [7:0] seq_model = 8'h00;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [7:0] hexc(input logic [3:0] n);
      if (n < 4'd10) return 8'h30 + {4'd0, n};
      return 8'h41 + ({4'd0, n} - 8'd10);
   endfunction

   task automatic push_frame(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
      logic [31:0] w[4];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
`ifdef DEBUG_DUMP_SEQ_EN
      exp_q.push_back(hexc(seq_model[7:4]));
      exp_q.push_back(hexc(seq_model[3:0]));
      exp_q.push_back(8'h3A);
      seq_model = seq_model + 8'd1;
`endif
      for (int i = 0; i < 4; i++) begin
         for (int n = 7; n >= 0; n--)
            exp_q.push_back(hexc(w[i][n*4 +: 4]));
         if (i < 3) exp_q.push_back(8'h20);
      end
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   // UART monitor: start detected on first low sample, bits sampled mid-bit.
   bit         mon_active = 1'b0;
   int         mon_cnt    = 0;
   logic [7:0] mon_byte   = 8'h00;
   always @(negedge clk) begin
      if (rst) begin
         mon_active = 1'b0;
      end else if (!mon_active) begin
         if (dbg.tx == 1'b0) begin
            mon_active = 1'b1;
            mon_cnt    = 0;
         end
      end else begin
         mon_cnt++;
         if (mon_cnt % CPB == CPB / 2) begin
            if (mon_cnt / CPB == 0) begin
               check_val("start_bit", dbg.tx, 0);
            end else if (mon_cnt / CPB <= 8) begin
               mon_byte[mon_cnt / CPB - 1] = dbg.tx;
            end else begin
               check_val("stop_bit", dbg.tx, 1);
               if (exp_q.size() == 0)
                  check_val("rx_unexpected", {24'd0, mon_byte}, 32'hFFFF_FFFF);
               else
                  check_val($sformatf("char%0d", rx_count), {24'd0, mon_byte},
                            {24'd0, exp_q.pop_front()});
               rx_count++;
               mon_active = 1'b0;
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_trigger;
      dbg.trigger = 1'b1;
      tick();
      dbg.trigger = 1'b0;
   endtask

   // Counts negedges with busy high for the frame in flight (bounded).
   task automatic wait_frame(output int busy_cycles);
      int guard = 0;
      int n = 0;
      busy_cycles = 0;
      @(negedge clk);
      while (!dbg.busy && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!dbg.busy) begin
         check_val("busy_rise_timeout", 0, 1);
         return;
      end
      while (dbg.busy && n < 3000) begin
         n++;
         @(negedge clk);
      end
      if (dbg.busy) check_val("busy_fall_timeout", 0, 1);
      busy_cycles = n;
      repeat (4) tick();
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bc;
      int rx0;
      int frames;
      logic prev_busy;

      dbg.trigger = 1'b0;
      dbg.word0 = '0; dbg.word1 = '0; dbg.word2 = '0; dbg.word3 = '0;

      // 1. reset held 5 cycles, then released
      for (int i = 0; i < 5; i++) begin
         tick();
         check_val("rst_tx", dbg.tx, 1);
         check_val("rst_busy", dbg.busy, 0);
         check_val("rst_dropped", dbg.dropped, 0);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val("post_rst_tx", dbg.tx, 1);
         check_val("post_rst_busy", dbg.busy, 0);
      end
      $display("reset: done");

      // 2. basic frame, words change right after launch
      dbg.word0 = 32'h0000_0000; dbg.word1 = 32'h0000_001C;
      dbg.word2 = 32'h00A0_0093; dbg.word3 = 32'hDEAD_BEEF;
      push_frame(dbg.word0, dbg.word1, dbg.word2, dbg.word3);
      rx0 = rx_count;
      pulse_trigger();
      dbg.word0 = $urandom; dbg.word1 = $urandom; dbg.word2 = $urandom; dbg.word3 = $urandom;
      wait_frame(bc);
      check_val("f1_busy_len", bc, FRAME_CYC);
      check_val("f1_chars", rx_count - rx0, FRAME_LEN);
      check_val("f1_dropped", dbg.dropped, 0);
      $display("frame basic: busy=%0d chars=%0d", bc, rx_count - rx0);

      // 3. trigger held high: exactly one frame
      dbg.word0 = 32'h1234_5678; dbg.word1 = 32'h9ABC_DEF0;
      dbg.word2 = 32'h0F1E_2D3C; dbg.word3 = 32'hA5A5_5A5A;
      push_frame(dbg.word0, dbg.word1, dbg.word2, dbg.word3);
      rx0 = rx_count;
      frames = 0;
      prev_busy = dbg.busy;
      dbg.trigger = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (dbg.busy && !prev_busy) frames++;
         prev_busy = dbg.busy;
      end
      dbg.trigger = 1'b0;
      tick();
      check_val("held_frames", frames, 1);
      check_val("held_dropped", dbg.dropped, 0);
      check_val("held_chars", rx_count - rx0, FRAME_LEN);
      $display("held trigger: frames=%0d", frames);

      // 4. triggers while busy are counted and saturate
      dbg.word0 = 32'hCAFE_F00D; dbg.word1 = 32'h0000_0001;
      dbg.word2 = 32'hFFFF_FFFF; dbg.word3 = 32'h7654_3210;
      push_frame(dbg.word0, dbg.word1, dbg.word2, dbg.word3);
      rx0 = rx_count;
      pulse_trigger();
      repeat (5 * 10 * CPB + 2 * CPB) tick();
      pulse_trigger();
      tick();
      check_val("drop_one", dbg.dropped, 1);
      for (int i = 0; i < 300; i++) begin
         pulse_trigger();
         tick();
      end
      check_val("drop_still_busy", dbg.busy, 1);
      check_val("drop_sat", dbg.dropped, 8'hFF);
      wait_frame(bc);
      check_val("drop_chars", rx_count - rx0, FRAME_LEN);
      $display("dropped: count=0x%0h chars=%0d", dbg.dropped, rx_count - rx0);

      // 5. reset mid-frame aborts; next trigger gives a full fresh frame
      push_frame(32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888);
      dbg.word0 = 32'h1111_2222; dbg.word1 = 32'h3333_4444;
      dbg.word2 = 32'h5555_6666; dbg.word3 = 32'h7777_8888;
      pulse_trigger();
      repeat (10 * 10 * CPB + 3 * CPB) tick();
      rst = 1'b1;
      #1;
      check_val("abort_tx", dbg.tx, 1);
      check_val("abort_busy", dbg.busy, 0);
      exp_q.delete();
      seq_model = 8'h00;
      tick();
      tick();
      check_val("abort_dropped", dbg.dropped, 0);
      rst = 1'b0;
      tick();
      rx0 = rx_count;
      dbg.word0 = 32'hABCD_EF01; dbg.word1 = 32'h2345_6789;
      dbg.word2 = 32'h0000_0093; dbg.word3 = 32'h8000_0000;
      push_frame(dbg.word0, dbg.word1, dbg.word2, dbg.word3);
      pulse_trigger();
      wait_frame(bc);
      check_val("restart_busy_len", bc, FRAME_CYC);
      check_val("restart_chars", rx_count - rx0, FRAME_LEN);
      $display("reset abort: restart chars=%0d", rx_count - rx0);

      // 6. two back-to-back frames from a clean reset (sequence prefix when enabled)
      rst = 1'b1;
      exp_q.delete();
      seq_model = 8'h00;
      tick();
      tick();
      rst = 1'b0;
      tick();
      for (int f = 0; f < 2; f++) begin
         rx0 = rx_count;
         dbg.word0 = $urandom; dbg.word1 = $urandom; dbg.word2 = $urandom; dbg.word3 = $urandom;
         push_frame(dbg.word0, dbg.word1, dbg.word2, dbg.word3);
         pulse_trigger();
         wait_frame(bc);
         check_val($sformatf("seq%0d_busy_len", f), bc, FRAME_CYC);
         check_val($sformatf("seq%0d_chars", f), rx_count - rx0, FRAME_LEN);
         $display("frame %0d: busy=%0d chars=%0d", f, bc, rx_count - rx0);
      end

      check_val("exp_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
